// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data bits LSB first, odd parity, stop, ack.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that aborts a stalled transfer.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_nak,
  output logic       tx_timeout,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } state_e;

  state_e           state_q;
  logic [7:0]       data_q;
  logic             parity_q;
  logic [3:0]       bit_cnt_q;
  logic [INH_W-1:0] inh_cnt_q;
  logic             ack_q;
  logic             tx_ready_q;
  logic             tx_done_q;
  logic             tx_nak_q;
  logic             clk_oe_q;
  logic             data_oe_q;

  logic clk_meta_q, clk_sync_q, clk_prev_q;
  logic data_meta_q, data_sync_q;
  logic clk_fall;
  logic frame_bit_d;
  logic wd_expire;

  // Both lines idle high, so the synchronizers reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so each flop samples its pre-edge source.
      clk_meta_q  <= ps2_clk_in;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_in;
      data_sync_q <= data_meta_q;
    end
  end

  assign clk_fall = clk_prev_q & ~clk_sync_q;

  always_comb begin
    // NOTE: default assignment first so this block can never infer a latch.
    frame_bit_d = parity_q;
    if (!bit_cnt_q[3]) frame_bit_d = data_q[bit_cnt_q[2:0]];
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_active;
  logic            tx_timeout_q;

  assign wd_active = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
  assign wd_expire = wd_active && !clk_fall && (wd_cnt_q == WD_LAST);

  // Counts device silence; any device clock edge proves the device is still alive.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q     <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tx_timeout_q <= wd_expire;
      if (clk_fall || state_q == START) begin
        wd_cnt_q <= '0;
      end else if (wd_active && !wd_expire) begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
    end
  end

  assign tx_timeout = tx_timeout_q;
`else
  assign wd_expire  = 1'b0;
  assign tx_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      data_q     <= 8'h00;
      parity_q   <= 1'b0;
      bit_cnt_q  <= 4'd0;
      inh_cnt_q  <= '0;
      ack_q      <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_nak_q   <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      tx_nak_q  <= 1'b0;
      if (wd_expire) begin
        state_q    <= IDLE;
        clk_oe_q   <= 1'b0;
        data_oe_q  <= 1'b0;
        tx_ready_q <= 1'b1;
        tx_done_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (tx_valid && tx_ready_q) begin
              data_q     <= tx_data;
              parity_q   <= ~^tx_data;
              inh_cnt_q  <= '0;
              clk_oe_q   <= 1'b1;
              data_oe_q  <= 1'b0;
              tx_ready_q <= 1'b0;
              state_q    <= INHIBIT;
            end
          end
          INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
              data_oe_q <= 1'b1;
              state_q   <= START;
            end else begin
              inh_cnt_q <= inh_cnt_q + INH_W'(1);
            end
          end
          START: begin
            clk_oe_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
            state_q   <= SEND;
          end
          SEND: begin
            // Edges 1-9 put data then parity on the line; edge 10 releases it as the stop bit.
            if (clk_fall) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd9) begin
                data_oe_q <= 1'b0;
                state_q   <= ACK;
              end else begin
                data_oe_q <= ~frame_bit_d;
              end
            end
          end
          ACK: begin
            if (clk_fall) begin
              ack_q   <= data_sync_q;
              state_q <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (clk_sync_q && data_sync_q) begin
              tx_done_q  <= 1'b1;
              tx_nak_q   <= ack_q;
              tx_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
          default: begin
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_ready    = tx_ready_q;
  assign tx_done     = tx_done_q;
  assign tx_nak      = tx_nak_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, number of clk cycles the host holds PS2 clock low before the start bit (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 2000000, watchdog limit in clk cycles (used only under PS2_TX_TIMEOUT_EN).
REQ-003 clk  input  1  system clock; all logic on posedge clk; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tx_data  input  8  command byte to the device.
REQ-006 tx_valid  input  1  request to send tx_data.
REQ-007 tx_ready  output  1  high only in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
REQ-008 tx_done  output  1  one-cycle pulse when a transfer ends (normally, NAK or timeout).
REQ-009 tx_nak  output  1  valid with tx_done: 1 = device did not acknowledge (ack bit sampled 1).
REQ-010 tx_timeout  output  1  valid with tx_done: 1 = watchdog abort.
REQ-011 ps2_clk_in  input  1  raw PS2 clock line (asynchronous).
REQ-012 ps2_data_in  input  1  raw PS2 data line (asynchronous).
REQ-013 ps2_clk_oe  output  1  1 = pull PS2 clock low (open-drain); 0 = release.
REQ-014 ps2_data_oe  output  1  1 = pull PS2 data low; 0 = release.

Function
REQ-015 ps2_clk_in and ps2_data_in SHALL each pass a 2-flop synchronizer; a falling edge SHALL be detected as synced previous = 1 and synced current = 0.
REQ-016 States SHALL be IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe = 0, tx_ready = 1; on accept, tx_data SHALL be latched, odd parity computed (parity = ~^tx_data), and the next state SHALL be INHIBIT.
REQ-018 INHIBIT: clk_oe = 1, data_oe = 0, for exactly INHIBIT_CYCLES cycles, then START.
REQ-019 START: clk_oe = 1, data_oe = 1 (start bit 0) for exactly 1 cycle, then SEND.
REQ-020 SEND: clk_oe = 0, data_oe held; on falling edges 1-8 drive data bits 0-7 LSB first, on edge 9 drive parity, on edge 10 drive stop (data_oe = 0), then ACK; data_oe = ~bit, updated the cycle after edge detection.
REQ-021 ACK: both oe = 0; on the next falling edge, ack = synced data; tx_nak latched as ack == 1; next state WAIT_IDLE.
REQ-022 WAIT_IDLE: both oe = 0; when synced clk and data are both 1, pulse tx_done for 1 cycle and enter IDLE.
REQ-023 tx_valid while tx_ready = 0 SHALL be ignored; tx_data changes after accept SHALL not affect the frame.
REQ-024 Bit counter SHALL be 4 bits, clear on START, never wrap beyond 10.
REQ-025 Device clock edges in IDLE, INHIBIT or START SHALL be ignored.
REQ-026 tx_nak and tx_timeout SHALL be 0 whenever tx_done = 0.

Reset
REQ-027 On rst: state IDLE, tx_ready = 1 the next cycle, tx_done/tx_nak/tx_timeout = 0, both oe = 0, counters and synchronizers reset to idle-line values (1).
REQ-028 rst mid-transfer SHALL release both lines on the next clock edge with no tx_done pulse.

Configuration
REQ-029 Macro PS2_TX_TIMEOUT_EN: when defined, a counter SHALL reset on every falling edge and on entering START; if it reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, the block releases both lines, pulses tx_done with tx_timeout = 1, and returns to IDLE.
REQ-030 Without PS2_TX_TIMEOUT_EN: no watchdog logic, tx_timeout tied to 0, states wait indefinitely.

Verification
REQ-031 Send 0xED, device model acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done with tx_nak = 0, tx_timeout = 0.
REQ-032 Send 0x01 and 0xFF -> parity 0 and 1 respectively; clk_oe low for exactly INHIBIT_CYCLES + 1 cycles before release.
REQ-033 Device leaves data high on the ack clock -> tx_done with tx_nak = 1.
REQ-034 rst asserted after edge 5 of 0xF4 -> both oe = 0 next cycle, no tx_done, tx_ready = 1; a new 0xF4 then completes correctly.
REQ-035 With PS2_TX_TIMEOUT_EN and TIMEOUT_CYCLES = 100, device stops clocking after edge 3 -> tx_done with tx_timeout = 1 exactly 100 cycles after the last edge; without the macro, the state stays SEND.
REQ-036 tx_valid pulsed during INHIBIT with a different byte -> ignored; the original byte is sent unchanged.
